id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures the decode-stage control word produced by the control unit, plus register operands, immediate and register specifiers, and presents them to EX one cycle later.
- Inserts a one-cycle bubble and stalls PC and IF/ID on a load-use hazard.
- Squashes the captured instruction when EX redirects the PC (taken branch, jump, jr).

Parameters:
- DATA_WIDTH, 32, width of PC, operand and immediate datapaths
- REG_ADDR_WIDTH, 5, width of register specifiers
- CNT_WIDTH, 16, width of the saturating stall counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- id_valid  in  1  IF/ID holds a real instruction
- id_jr, id_jal, id_jump, id_reg_dst, id_branch_eq, id_branch_ne, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  decode control bits
- id_alu_op  in  4  decode ALU operation code
- id_pc_plus4  in  DATA_WIDTH  PC+4 of the ID instruction
- id_read_data1, id_read_data2  in  DATA_WIDTH  register file outputs
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_rs, id_rt, id_rd, id_shamt  in  REG_ADDR_WIDTH  instruction fields
- ex_redirect  in  1  EX resolved a taken branch, jump or jr this cycle
- ex_* (same names and widths as every id_* input, plus ex_valid)  out  registered copies for EX
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may update
- stall_count  out  CNT_WIDTH  number of load-use bubbles inserted, saturating

Behaviour:
- Reset: all ex_* outputs = 0, ex_valid = 0, stall_count = 0. Reset has priority over every other event.
- Combinational hazard condition: hazard = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs & uses_rs) | (ex_rt == id_rt & uses_rt)).
  - uses_rs = 1 for every valid instruction except J/JAL (id_jump=1).
  - uses_rt = id_reg_dst | id_branch_eq | id_branch_ne | id_mem_write.
- pc_write = if_id_write = ~hazard | ex_redirect. Both outputs are combinational; no extra latency.
- Per-edge update, in priority order:
  1. reset
  2. ex_redirect = 1: flush. All control outputs = 0, ex_valid = 0. Data fields may load or hold; they are don't-care.
  3. hazard = 1: bubble. All control outputs = 0, ex_valid = 0. stall_count increments and saturates at all-ones.
  4. Otherwise: all ex_* outputs load their id_* inputs; ex_valid = id_valid. If id_valid = 0, control bits load as 0.
- Bubble or flush zeroes reg_write, mem_write, mem_read, branch_eq/ne, jump, jr and jal, so the instruction has no architectural effect.
- Latency: one cycle from ID to EX.
- A load-use stall lasts exactly one cycle. After the bubble, ex_mem_read = 0, so hazard clears and the held instruction advances on the next edge.
- Simultaneous ex_redirect and hazard: the flush wins, pc_write = 1, and stall_count does not increment.
- A load to $0 never stalls.
- Back-to-back loads whose consumer depends on the second load stall once per dependency.
- Reset asserted mid-stall clears the stall immediately. pc_write = 1 in the cycle after reset deasserts, because ex_valid = 0.

Test Plan:
- Reset with all inputs nonzero -> all ex_* = 0, pc_write = 1, stall_count = 0, held for every reset cycle.
- ADDI in ID (reg_write=1, alu_src=1, alu_op=4, read_data1=0x0000_0010, imm=0x5) -> next cycle ex_reg_write=1, ex_alu_op=4, ex_read_data1=0x10, ex_imm=5, ex_valid=1.
- LW $t0 (rt=8) in EX, ADD with rs=8 in ID -> pc_write=0 and if_id_write=0 for one cycle, bubble has ex_reg_write=0 and ex_valid=0, ADD reaches EX on the following edge, stall_count=1.
- LW to rt=8 in EX, SW with rt=8 in ID -> stall. LW to rt=8, ADDI with rt=8 (destination only) -> no stall. LW to rt=0 -> no stall.
- ex_redirect=1 together with a hazard -> pc_write=1, ex_* control=0, ex_valid=0, stall_count unchanged.
- Force 2^CNT_WIDTH+3 load-use hazards -> stall_count holds 0xFFFF with no wrap to 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// Registers the decode control word and operands for EX, detects load-use
// hazards against the load currently in EX, inserts a one-cycle bubble while
// holding PC and IF/ID, and squashes the captured instruction on an EX redirect.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic                      id_jr,
    input  logic                      id_jal,
    input  logic                      id_jump,
    input  logic                      id_reg_dst,
    input  logic                      id_branch_eq,
    input  logic                      id_branch_ne,
    input  logic                      id_mem_read,
    input  logic                      id_mem_to_reg,
    input  logic                      id_mem_write,
    input  logic                      id_alu_src,
    input  logic                      id_reg_write,
    input  logic [3:0]                id_alu_op,
    input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
    input  logic [DATA_WIDTH-1:0]     id_read_data1,
    input  logic [DATA_WIDTH-1:0]     id_read_data2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd,
    input  logic [REG_ADDR_WIDTH-1:0] id_shamt,
    input  logic                      ex_redirect,
    output logic                      ex_valid,
    output logic                      ex_jr,
    output logic                      ex_jal,
    output logic                      ex_jump,
    output logic                      ex_reg_dst,
    output logic                      ex_branch_eq,
    output logic                      ex_branch_ne,
    output logic                      ex_mem_read,
    output logic                      ex_mem_to_reg,
    output logic                      ex_mem_write,
    output logic                      ex_alu_src,
    output logic                      ex_reg_write,
    output logic [3:0]                ex_alu_op,
    output logic [DATA_WIDTH-1:0]     ex_pc_plus4,
    output logic [DATA_WIDTH-1:0]     ex_read_data1,
    output logic [DATA_WIDTH-1:0]     ex_read_data2,
    output logic [DATA_WIDTH-1:0]     ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_rs,
    output logic [REG_ADDR_WIDTH-1:0] ex_rt,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [REG_ADDR_WIDTH-1:0] ex_shamt,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    logic usesRs;
    logic usesRt;
    logic hazard;
    logic squash;
    logic bubble;

    // Load-use detection: the load in EX writes a register the ID instruction reads.
    always_comb begin
        usesRs = ~id_jump;
        usesRt = id_reg_dst | id_branch_eq | id_branch_ne | id_mem_write;
        hazard = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                 (((ex_rt == id_rs) & usesRs) | ((ex_rt == id_rt) & usesRt));
    end

    // A redirect discards the stalled instruction anyway, so it also releases the stall.
    assign pc_write    = ~hazard | ex_redirect;
    assign if_id_write = ~hazard | ex_redirect;

    // Flush, bubble and empty ID slots all present a no-op control word to EX.
    assign squash = ex_redirect | hazard | ~id_valid;
    assign bubble = hazard & ~ex_redirect;

    // Control word register: cleared on reset or squash, otherwise follows ID.
    always_ff @(posedge clk) begin
        if (reset || squash) begin
            ex_valid      <= 1'b0;
            ex_jr         <= 1'b0;
            ex_jal        <= 1'b0;
            ex_jump       <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_branch_eq  <= 1'b0;
            ex_branch_ne  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_alu_op     <= '0;
        end else begin
            ex_valid      <= 1'b1;
            ex_jr         <= id_jr;
            ex_jal        <= id_jal;
            ex_jump       <= id_jump;
            ex_reg_dst    <= id_reg_dst;
            ex_branch_eq  <= id_branch_eq;
            ex_branch_ne  <= id_branch_ne;
            ex_mem_read   <= id_mem_read;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_mem_write  <= id_mem_write;
            ex_alu_src    <= id_alu_src;
            ex_reg_write  <= id_reg_write;
            ex_alu_op     <= id_alu_op;
        end
    end

    // Datapath register: loads every cycle; contents are ignored behind a no-op control word.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_pc_plus4   <= '0;
            ex_read_data1 <= '0;
            ex_read_data2 <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_shamt      <= '0;
        end else begin
            ex_pc_plus4   <= id_pc_plus4;
            ex_read_data1 <= id_read_data1;
            ex_read_data2 <= id_read_data2;
            ex_imm        <= id_imm;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_shamt      <= id_shamt;
        end
    end

    // Saturating count of load-use bubbles actually inserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (bubble && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction vectors push their
// hand-derived expected EX state into a queue; a monitor pops and compares.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    typedef struct packed {
        logic valid, jr, jal, jump, regDst, branchEq, branchNe;
        logic memRead, memToReg, memWrite, aluSrc, regWrite;
        logic [3:0] aluOp;
    } ctrl_t;

    typedef struct packed {
        logic [DW-1:0] pcPlus4, rd1, rd2, imm;
        logic [RW-1:0] rs, rt, rd, shamt;
    } data_t;

    typedef struct packed {
        ctrl_t c;
        data_t d;
    } instr_t;

    typedef struct {
        logic          pcw;
        ctrl_t         c;
        data_t         d;
        logic          chkData;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic ex_redirect;
    instr_t cur;

    logic ex_valid, ex_jr, ex_jal, ex_jump, ex_reg_dst, ex_branch_eq, ex_branch_ne;
    logic ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic [3:0] ex_alu_op;
    logic [DW-1:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd, ex_shamt;
    logic pc_write, if_id_write;
    logic [CW-1:0] stall_count;

    ctrl_t actC;
    data_t actD;
    assign actC = {ex_valid, ex_jr, ex_jal, ex_jump, ex_reg_dst, ex_branch_eq, ex_branch_ne,
                   ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op};
    assign actD = {ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt};

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(cur.c.valid), .id_jr(cur.c.jr), .id_jal(cur.c.jal), .id_jump(cur.c.jump),
        .id_reg_dst(cur.c.regDst), .id_branch_eq(cur.c.branchEq), .id_branch_ne(cur.c.branchNe),
        .id_mem_read(cur.c.memRead), .id_mem_to_reg(cur.c.memToReg), .id_mem_write(cur.c.memWrite),
        .id_alu_src(cur.c.aluSrc), .id_reg_write(cur.c.regWrite), .id_alu_op(cur.c.aluOp),
        .id_pc_plus4(cur.d.pcPlus4), .id_read_data1(cur.d.rd1), .id_read_data2(cur.d.rd2),
        .id_imm(cur.d.imm), .id_rs(cur.d.rs), .id_rt(cur.d.rt), .id_rd(cur.d.rd),
        .id_shamt(cur.d.shamt), .ex_redirect(ex_redirect),
        .ex_valid(ex_valid), .ex_jr(ex_jr), .ex_jal(ex_jal), .ex_jump(ex_jump),
        .ex_reg_dst(ex_reg_dst), .ex_branch_eq(ex_branch_eq), .ex_branch_ne(ex_branch_ne),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
        .ex_pc_plus4(ex_pc_plus4), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
    );

    // Instruction builders (MIPS-style field usage)
    function automatic instr_t lw(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
        instr_t i = '0;
        i.c.valid = 1'b1; i.c.memRead = 1'b1; i.c.memToReg = 1'b1;
        i.c.regWrite = 1'b1; i.c.aluSrc = 1'b1; i.c.aluOp = 4'd0;
        i.d.rs = rs; i.d.rt = rt; i.d.imm = 32'd4; i.d.pcPlus4 = 32'h0000_0100;
        i.d.rd1 = 32'h0000_1000;
        return i;
    endfunction

    function automatic instr_t addi(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                    input logic [DW-1:0] rd1, input logic [DW-1:0] imm);
        instr_t i = '0;
        i.c.valid = 1'b1; i.c.regWrite = 1'b1; i.c.aluSrc = 1'b1; i.c.aluOp = 4'd4;
        i.d.rs = rs; i.d.rt = rt; i.d.rd1 = rd1; i.d.imm = imm; i.d.pcPlus4 = 32'h0000_0104;
        return i;
    endfunction

    function automatic instr_t add(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                   input logic [RW-1:0] rd);
        instr_t i = '0;
        i.c.valid = 1'b1; i.c.regDst = 1'b1; i.c.regWrite = 1'b1; i.c.aluOp = 4'd2;
        i.d.rs = rs; i.d.rt = rt; i.d.rd = rd; i.d.rd1 = 32'h0000_0007;
        i.d.rd2 = 32'h0000_0009; i.d.pcPlus4 = 32'h0000_0108;
        return i;
    endfunction

    function automatic instr_t sw(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
        instr_t i = '0;
        i.c.valid = 1'b1; i.c.memWrite = 1'b1; i.c.aluSrc = 1'b1;
        i.d.rs = rs; i.d.rt = rt; i.d.imm = 32'h0000_0008; i.d.pcPlus4 = 32'h0000_010C;
        return i;
    endfunction

    function automatic instr_t jmp();
        instr_t i = '0;
        i.c.valid = 1'b1; i.c.jump = 1'b1;
        i.d.rs = 5'd8; i.d.rt = 5'd8; i.d.pcPlus4 = 32'h0000_0110;
        return i;
    endfunction

    function automatic instr_t beq(input logic [RW-1:0] rs, input logic [RW-1:0] rt);
        instr_t i = '0;
        i.c.valid = 1'b1; i.c.branchEq = 1'b1; i.c.aluOp = 4'd1;
        i.d.rs = rs; i.d.rt = rt; i.d.imm = 32'hFFFF_FFFC; i.d.pcPlus4 = 32'h0000_0114;
        return i;
    endfunction

    // mode: 0 = instruction lands in EX, 1 = bubble/flush (data don't-care),
    //       2 = reset (everything zero), 3 = invalid slot (control zero, data loads)
    task automatic drive(input instr_t ins, input logic rst, input logic redir,
                         input int mode, input logic pcw, input int cnt);
        exp_t e;
        cur = ins;
        reset = rst;
        ex_redirect = redir;
        e.pcw = pcw;
        e.cnt = CW'(cnt);
        e.c = '0;
        e.d = '0;
        e.chkData = 1'b1;
        case (mode)
            0: begin e.c = ins.c; e.d = ins.d; end
            1: e.chkData = 1'b0;
            2: ;
            default: e.d = ins.d;
        endcase
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: combinational stall outputs before the edge, registered state after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (pc_write !== e.pcw) begin
                    bad++;
                    $display("FAIL pc_write: got %b want %b at %0t", pc_write, e.pcw, $time);
                end
                total++;
                if (if_id_write !== e.pcw) begin
                    bad++;
                    $display("FAIL if_id_write: got %b want %b at %0t", if_id_write, e.pcw, $time);
                end
                @(posedge clk);
                #1;
                total++;
                if (actC !== e.c) begin
                    bad++;
                    $display("FAIL ex_ctrl: got %h want %h at %0t", actC, e.c, $time);
                end
                if (e.chkData) begin
                    total++;
                    if (actD !== e.d) begin
                        bad++;
                        $display("FAIL ex_data: got %h want %h at %0t", actD, e.d, $time);
                    end
                end
                total++;
                if (stall_count !== e.cnt) begin
                    bad++;
                    $display("FAIL stall_count: got %0d want %0d at %0t", stall_count, e.cnt, $time);
                end
            end
        end
    end

    initial begin
        instr_t ones;
        instr_t inv;
        ones = '1;
        inv = '1;
        inv.c.valid = 1'b0;
        cur = '0;
        reset = 1'b1;
        ex_redirect = 1'b0;
        @(posedge clk);
        #2;

        // reset held with every input driven high
        repeat (3) drive(ones, 1'b1, 1'b1, 2, 1'b1, 0);

        // ADDI lands in EX; then an invalid slot with control bits set
        drive(addi(5'd1, 5'd9, 32'h10, 32'h5), 1'b0, 1'b0, 0, 1'b1, 0);
        drive(inv, 1'b0, 1'b0, 3, 1'b1, 0);

        // LW $8 then ADD reading rs=$8: one bubble, then ADD advances
        drive(lw(5'd29, 5'd8), 1'b0, 1'b0, 0, 1'b1, 0);
        drive(add(5'd8, 5'd10, 5'd11), 1'b0, 1'b0, 1, 1'b0, 1);
        drive(add(5'd8, 5'd10, 5'd11), 1'b0, 1'b0, 0, 1'b1, 1);

        // LW $8 then SW storing $8 (rt use): stall
        drive(lw(5'd29, 5'd8), 1'b0, 1'b0, 0, 1'b1, 1);
        drive(sw(5'd5, 5'd8), 1'b0, 1'b0, 1, 1'b0, 2);
        drive(sw(5'd5, 5'd8), 1'b0, 1'b0, 0, 1'b1, 2);

        // LW $8 then ADDI writing $8 only: no stall
        drive(lw(5'd29, 5'd8), 1'b0, 1'b0, 0, 1'b1, 2);
        drive(addi(5'd1, 5'd8, 32'h3, 32'h7), 1'b0, 1'b0, 0, 1'b1, 2);

        // LW to $0 never stalls
        drive(lw(5'd29, 5'd0), 1'b0, 1'b0, 0, 1'b1, 2);
        drive(add(5'd0, 5'd0, 5'd3), 1'b0, 1'b0, 0, 1'b1, 2);

        // J does not read registers even if field bits match
        drive(lw(5'd29, 5'd8), 1'b0, 1'b0, 0, 1'b1, 2);
        drive(jmp(), 1'b0, 1'b0, 0, 1'b1, 2);

        // redirect together with a hazard: flush wins, count unchanged
        drive(lw(5'd29, 5'd8), 1'b0, 1'b0, 0, 1'b1, 2);
        drive(beq(5'd8, 5'd2), 1'b0, 1'b1, 1, 1'b1, 2);

        // back-to-back dependent loads
        drive(lw(5'd29, 5'd8), 1'b0, 1'b0, 0, 1'b1, 2);
        drive(lw(5'd8, 5'd9), 1'b0, 1'b0, 1, 1'b0, 3);
        drive(lw(5'd8, 5'd9), 1'b0, 1'b0, 0, 1'b1, 3);
        drive(add(5'd9, 5'd1, 5'd4), 1'b0, 1'b0, 1, 1'b0, 4);
        drive(add(5'd9, 5'd1, 5'd4), 1'b0, 1'b0, 0, 1'b1, 4);

        // reset asserted mid-stall
        drive(lw(5'd29, 5'd8), 1'b0, 1'b0, 0, 1'b1, 4);
        drive(add(5'd8, 5'd10, 5'd11), 1'b1, 1'b0, 2, 1'b0, 0);
        drive(add(5'd8, 5'd10, 5'd11), 1'b0, 1'b0, 0, 1'b1, 0);

        // 2^CW+3 hazards: counter must saturate, not wrap
        drive(lw(5'd8, 5'd8), 1'b0, 1'b0, 0, 1'b1, 0);
        for (int k = 1; k <= (1 << CW) + 3; k++) begin
            drive(lw(5'd8, 5'd8), 1'b0, 1'b0, 1, 1'b0, (k > 15) ? 15 : k);
            drive(lw(5'd8, 5'd8), 1'b0, 1'b0, 0, 1'b1, (k > 15) ? 15 : k);
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
